// File: rtl/subtractor_brentkung_16u_pipe.sv
// ---------------------------------------------------------------------------
// subtractor_brentkung_16u_pipe
//   Three-stage pipelined subtractor: diff = a - b - bin, evaluated as
//   a + ~b + ~bin through a Brent-Kung prefix carry tree.
//     S1 : per-bit propagate/generate of a + ~b, carry-in = ~bin
//     S2 : up-sweep of the prefix tree (carry-in folded into bit 0)
//     S3 : down-sweep, sum bits, borrow/overflow/zero flags
//   Valid/ready on both sides with full back-pressure; bubbles collapse,
//   so up to three beats are buffered while the output is stalled.
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    operand handshake (a, b, bin)
//   out_valid/out_ready  result handshake (diff, bout, ovf, zero)
//   diff                 (a - b - bin) mod 2^WIDTH
//   bout                 borrow out (a < b + bin, unsigned)
//   ovf                  signed overflow of the subtraction
//   zero                 diff == 0
// ---------------------------------------------------------------------------
module subtractor_brentkung_16u_pipe #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);

   localparam int LOG = $clog2(WIDTH);

   if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("WIDTH must be a power of two in 4..64");
   end

   // stage valids
   logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic en1, en2, en3;

   // S1 registers
   logic [WIDTH-1:0] p1_q, p1_d, g1_q, g1_d;
   logic             cin1_q, cin1_d, am1_q, am1_d, bm1_q, bm1_d;

   // S2 registers: in-place up-swept (g,p) plus the raw bit propagates for the sum
   logic [WIDTH-1:0] gu2_q, gu2_d, pu2_q, pu2_d, p2_q, p2_d;
   logic             cin2_q, cin2_d, am2_q, am2_d, bm2_q, bm2_d;

   // S3 registers
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;

   // handshake: each stage loads when it is empty or being drained this cycle
   always_comb begin
      en3      = v2_q & (~v3_q | out_ready);
      en2      = v1_q & (~v2_q | en3);
      en1      = in_valid & (~v1_q | en2);
      in_ready = ~v1_q | en2;
      v1_d     = en1 ? 1'b1 : (en2 ? 1'b0 : v1_q);
      v2_d     = en2 ? 1'b1 : (en3 ? 1'b0 : v2_q);
      v3_d     = en3 ? 1'b1 : ((v3_q & out_ready) ? 1'b0 : v3_q);
   end

   // S1: subtract as a + ~b + ~bin
   always_comb begin
      p1_d   = p1_q;
      g1_d   = g1_q;
      cin1_d = cin1_q;
      am1_d  = am1_q;
      bm1_d  = bm1_q;
      if (en1) begin
         p1_d   = a ^ ~b;
         g1_d   = a & ~b;
         cin1_d = ~bin;
         am1_d  = a[WIDTH-1];
         bm1_d  = b[WIDTH-1];
      end
   end

   // S2: up-sweep. After it, position 2^k-1 holds the full prefix G[2^k-1:0]
   // and every other position holds the group ending there.
   logic [WIDTH-1:0] gu, pu;
   always_comb begin
      gu    = g1_q;
      pu    = p1_q;
      gu[0] = g1_q[0] | (p1_q[0] & cin1_q);
      for (int l = 0; l < LOG; l++) begin
         for (int i = (2 << l) - 1; i < WIDTH; i += (2 << l)) begin
            gu[i] = gu[i] | (pu[i] & gu[i - (1 << l)]);
            pu[i] = pu[i] & pu[i - (1 << l)];
         end
      end
      gu2_d  = en2 ? gu     : gu2_q;
      pu2_d  = en2 ? pu     : pu2_q;
      p2_d   = en2 ? p1_q   : p2_q;
      cin2_d = en2 ? cin1_q : cin2_q;
      am2_d  = en2 ? am1_q  : am2_q;
      bm2_d  = en2 ? bm1_q  : bm2_q;
   end

   // S3: down-sweep fills the remaining prefixes, then sum and flags
   logic [WIDTH-1:0] gd, carry, sum;
   always_comb begin
      gd = gu2_q;
      for (int l = LOG - 2; l >= 0; l--) begin
         for (int i = 3 * (1 << l) - 1; i < WIDTH; i += (2 << l)) begin
            gd[i] = gd[i] | (pu2_q[i] & gd[i - (1 << l)]);
         end
      end
      carry  = {gd[WIDTH-2:0], cin2_q};
      sum    = p2_q ^ carry;
      diff_d = diff_q;
      bout_d = bout_q;
      ovf_d  = ovf_q;
      zero_d = zero_q;
      if (en3) begin
         diff_d = sum;
         bout_d = ~gd[WIDTH-1];
         ovf_d  = (am2_q ^ bm2_q) & (am2_q ^ sum[WIDTH-1]);
         zero_d = (sum == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         v3_q   <= 1'b0;
         p1_q   <= '0;
         g1_q   <= '0;
         cin1_q <= 1'b0;
         am1_q  <= 1'b0;
         bm1_q  <= 1'b0;
         gu2_q  <= '0;
         pu2_q  <= '0;
         p2_q   <= '0;
         cin2_q <= 1'b0;
         am2_q  <= 1'b0;
         bm2_q  <= 1'b0;
         diff_q <= '0;
         bout_q <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         v1_q   <= v1_d;
         v2_q   <= v2_d;
         v3_q   <= v3_d;
         p1_q   <= p1_d;
         g1_q   <= g1_d;
         cin1_q <= cin1_d;
         am1_q  <= am1_d;
         bm1_q  <= bm1_d;
         gu2_q  <= gu2_d;
         pu2_q  <= pu2_d;
         p2_q   <= p2_d;
         cin2_q <= cin2_d;
         am2_q  <= am2_d;
         bm2_q  <= bm2_d;
         diff_q <= diff_d;
         bout_q <= bout_d;
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

   assign out_valid = v3_q;
   assign diff      = diff_q;
   assign bout      = bout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_subtractor_brentkung_16u_pipe.sv
// Directed and random checks for subtractor_brentkung_16u_pipe.
module tb_subtractor_brentkung_16u_pipe;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n, in_valid, in_ready, bin, out_valid, out_ready;
   logic         bout, ovf, zero;
   logic [W-1:0] a, b, diff;
   int           vectors = 0;
   int           miscompares = 0;

   always #5 clk = ~clk;

   subtractor_brentkung_16u_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // one beat into an empty pipe; returns result and cycles until out_valid
   task automatic send_one(input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                           output logic [15:0] d, output logic [2:0] fl, output int lat);
      in_valid  = 1'b1;
      a         = ia;
      b         = ib;
      bin       = ibin;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      d  = diff;
      fl = {bout, ovf, zero};
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || diff !== 16'h0 || {bout, ovf, zero} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_outputs: got v=%b d=%h f=%b expected v=0 d=0000 f=000",
                  out_valid, diff, {bout, ovf, zero});
      end
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_basic();
      logic [15:0] ta [9] = '{16'h0005, 16'h0000, 16'h8000, 16'h1234, 16'h1234,
                              16'h7FFF, 16'hFFFF, 16'h0000, 16'h8000};
      logic [15:0] tb [9] = '{16'h0003, 16'h0001, 16'h0001, 16'h1234, 16'h1234,
                              16'hFFFF, 16'h0000, 16'h0000, 16'h7FFF};
      logic        tbin [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [15:0] ed [9] = '{16'h0002, 16'hFFFF, 16'h7FFF, 16'h0000, 16'hFFFF,
                              16'h8000, 16'hFFFE, 16'h0000, 16'h0001};
      // {bout, ovf, zero}
      logic [2:0]  ef [9] = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b100,
                              3'b110, 3'b000, 3'b001, 3'b010};
      logic [15:0] d;
      logic [2:0]  fl;
      int          lat;
      for (int i = 0; i < 9; i++) begin
         send_one(ta[i], tb[i], tbin[i], d, fl, lat);
         vectors++;
         if (lat !== 3) begin
            miscompares++;
            $display("FAIL basic_latency[%0d]: got %0d expected 3", i, lat);
         end
         vectors++;
         if (d !== ed[i] || fl !== ef[i]) begin
            miscompares++;
            $display("FAIL basic_result[%0d]: got d=%h f=%b expected d=%h f=%b",
                     i, d, fl, ed[i], ef[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         in_valid = (c < 8);
         a        = 16'(c * 16'h1111);
         b        = 16'(c * 16'h0101);
         bin      = 1'b0;
         #1;
         if (c < 8) begin
            vectors++;
            if (in_ready !== 1'b1) begin
               miscompares++;
               $display("FAIL b2b_in_ready[%0d]: got %b expected 1", c, in_ready);
            end
         end
         vectors++;
         if (out_valid !== (c >= 3 && c < 11)) begin
            miscompares++;
            $display("FAIL b2b_out_valid[%0d]: got %b expected %b", c, out_valid, (c >= 3 && c < 11));
         end
         if (c >= 3 && c < 11) begin
            vectors++;
            if (diff !== 16'((c - 3) * 16'h1010) || bout !== 1'b0) begin
               miscompares++;
               $display("FAIL b2b_diff[%0d]: got %h/%b expected %h/0", c, diff, bout,
                        16'((c - 3) * 16'h1010));
            end
         end
         step();
      end
   endtask

   task automatic test_stall();
      logic [15:0] sa [4] = '{16'h0050, 16'h1000, 16'hABCD, 16'h0001};
      logic [15:0] sb [4] = '{16'h0020, 16'h0001, 16'h0BCD, 16'h0002};
      logic [15:0] ed [4] = '{16'h0030, 16'h0FFF, 16'hA000, 16'hFFFF};
      int j = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         in_valid = 1'b1; a = sa[j]; b = sb[j]; bin = 1'b0;
         #1;
         vectors++;
         if (in_ready !== (c < 3)) begin
            miscompares++;
            $display("FAIL stall_in_ready[%0d]: got %b expected %b", c, in_ready, (c < 3));
         end
         if (c >= 3) begin
            vectors++;
            if (out_valid !== 1'b1 || diff !== ed[0]) begin
               miscompares++;
               $display("FAIL stall_hold[%0d]: got v=%b d=%h expected v=1 d=%h", c, out_valid, diff, ed[0]);
            end
         end
         if (in_ready) j++;
         step();
      end
      vectors++;
      if (j !== 3) begin
         miscompares++;
         $display("FAIL stall_accepted: got %0d expected 3", j);
      end
      out_ready = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL stall_release_ready: got %b expected 1", in_ready);
      end
      step();
      in_valid = 1'b0;
      for (int k = 1; k < 4; k++) begin
         #1;
         vectors++;
         if (out_valid !== 1'b1 || diff !== ed[k]) begin
            miscompares++;
            $display("FAIL stall_drain[%0d]: got v=%b d=%h expected v=1 d=%h", k, out_valid, diff, ed[k]);
         end
         step();
      end
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_empty: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_reset_flight();
      logic [15:0] d;
      logic [2:0]  fl;
      int          lat;
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1; a = 16'h0009 + 16'(c); b = 16'h0004; bin = 1'b0;
         step();
      end
      in_valid = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL flight_loaded: got %b expected 1", out_valid);
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || diff !== 16'h0 || {bout, ovf, zero} !== 3'b000) begin
         miscompares++;
         $display("FAIL flight_reset: got v=%b d=%h f=%b expected v=0 d=0000 f=000",
                  out_valid, diff, {bout, ovf, zero});
      end
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         vectors++;
         if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flight_ghost[%0d]: got %b expected 0", c, out_valid);
         end
      end
      send_one(16'h00C8, 16'h0064, 1'b0, d, fl, lat);
      vectors++;
      if (lat !== 3 || d !== 16'h0064 || fl !== 3'b000) begin
         miscompares++;
         $display("FAIL flight_after: got lat=%0d d=%h f=%b expected lat=3 d=0064 f=000", lat, d, fl);
      end
   endtask

   task automatic test_random();
      logic [18:0] q[$];
      logic [18:0] e;
      logic [16:0] t;
      logic [15:0] ed, prev_diff;
      logic        prev_hold = 1'b0;
      int          sent = 0, got = 0, cycles = 0;
      prev_diff = '0;
      while ((sent < 10000 || got < sent) && cycles < 60000) begin
         in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
         a         = 16'($urandom);
         b         = 16'($urandom);
         bin       = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (prev_hold) begin
            vectors++;
            if (out_valid !== 1'b1 || diff !== prev_diff) begin
               miscompares++;
               $display("FAIL rand_stable: got v=%b d=%h expected v=1 d=%h", out_valid, diff, prev_diff);
            end
         end
         if (in_valid && in_ready) begin
            t  = {1'b0, a} - {1'b0, b} - {16'h0, bin};
            ed = t[15:0];
            q.push_back({t[16], (a[15] ^ b[15]) & (a[15] ^ ed[15]), ed == 16'h0, ed});
            sent++;
         end
         if (out_valid && out_ready) begin
            vectors++;
            if (q.size() == 0) begin
               miscompares++;
               $display("FAIL rand_spurious: got d=%h expected no result", diff);
            end else begin
               e = q.pop_front();
               if ({bout, ovf, zero, diff} !== e) begin
                  miscompares++;
                  $display("FAIL rand_result[%0d]: got %b_%h expected %b_%h",
                           got, {bout, ovf, zero}, diff, e[18:16], e[15:0]);
               end
            end
            got++;
         end
         prev_hold = out_valid && !out_ready;
         prev_diff = diff;
         step();
         cycles++;
      end
      in_valid = 1'b0;
      vectors++;
      if (got !== 10000) begin
         miscompares++;
         $display("FAIL rand_timeout: got %0d results expected 10000", got);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_stall();
      test_reset_flight();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
